// File: rtl/game_physics_if.sv
// Pong game-state bus: frame tick and button inputs in, pad/ball/score state out.
// Latency: none, plain wires between the frame source and the physics engine.
// Backpressure: none; the engine samples inputs only on frame_tick and never stalls.
interface game_physics_if;
  logic       frame_tick;
  logic       btn_left_up;
  logic       btn_left_down;
  logic       btn_right_up;
  logic       btn_right_down;
  logic       btn_start;
  logic [8:0] pad_left;
  logic [8:0] pad_right;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       point_left;
  logic       point_right;
  logic       game_over;

  // Frame source / controller side.
  modport master (
    output frame_tick, btn_left_up, btn_left_down, btn_right_up, btn_right_down, btn_start,
    input  pad_left, pad_right, ball_x, ball_y, score_left, score_right,
    input  point_left, point_right, game_over
  );

  // Physics engine side.
  modport slave (
    input  frame_tick, btn_left_up, btn_left_down, btn_right_up, btn_right_down, btn_start,
    output pad_left, pad_right, ball_x, ball_y, score_left, score_right,
    output point_left, point_right, game_over
  );
endinterface

// File: rtl/game_physics.sv
// Per-frame pong engine: pads, ball, scores and the serve/play/game-over sequencing.
// Latency: all outputs registered, updated one clock after a sampled frame_tick.
// Backpressure: none; every frame_tick (even back-to-back) is a complete update.
module game_physics #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PAD_DISTANCE  = 16,
  parameter int PAD_WIDTH     = 8,
  parameter int PAD_HEIGHT    = 64,
  parameter int BALL_SIZE     = 8,
  parameter int PAD_SPEED     = 4,
  parameter int BALL_SPEED    = 4,
  parameter int SERVE_FRAMES  = 60,
  parameter int WIN_SCORE     = 3
) (
  input logic           clk_vga,
  input logic           rst,
  game_physics_if.slave gp
);

  // Geometry, pre-sized to the coordinate widths so every compare is same-width unsigned.
  localparam logic [8:0] PMIN   = 9'(PAD_HEIGHT / 2);
  localparam logic [8:0] PMAX   = 9'(SCREEN_HEIGHT - PAD_HEIGHT / 2);
  localparam logic [8:0] PSPD   = 9'(PAD_SPEED);
  localparam logic [8:0] TY     = 9'(BALL_SIZE / 2);
  localparam logic [8:0] BY     = 9'(SCREEN_HEIGHT - 1 - BALL_SIZE / 2);
  localparam logic [8:0] BSPD_Y = 9'(BALL_SPEED);
  localparam logic [9:0] BSPD_X = 10'(BALL_SPEED);
  localparam logic [9:0] LX     = 10'(PAD_DISTANCE + PAD_WIDTH + BALL_SIZE / 2);
  localparam logic [9:0] RX     = 10'(SCREEN_WIDTH - (PAD_DISTANCE + PAD_WIDTH + BALL_SIZE / 2));
  localparam logic [9:0] XMIN   = 10'(BALL_SIZE / 2);
  localparam logic [9:0] XMAX   = 10'(SCREEN_WIDTH - 1 - BALL_SIZE / 2);
  localparam logic [8:0] HIT    = 9'(PAD_HEIGHT / 2 + BALL_SIZE / 2);
  localparam logic [9:0] CX     = 10'(SCREEN_WIDTH / 2);
  localparam logic [8:0] CY     = 9'(SCREEN_HEIGHT / 2);
  localparam logic [3:0] WIN    = 4'(WIN_SCORE);

  localparam int CW = (SERVE_FRAMES < 1) ? 1 : $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] SERVE_INIT = CW'(SERVE_FRAMES);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] serve_cnt_q, serve_cnt_d;
  logic [8:0]    pad_left_q, pad_left_d;
  logic [8:0]    pad_right_q, pad_right_d;
  logic [9:0]    ball_x_q, ball_x_d;
  logic [8:0]    ball_y_q, ball_y_d;
  logic          dx_q, dx_d;       // 1: moving right (+x)
  logic          dy_q, dy_d;       // 1: moving down (+y)
  logic [3:0]    score_left_q, score_left_d;
  logic [3:0]    score_right_q, score_right_d;
  logic          point_left_q, point_left_d;
  logic          point_right_q, point_right_d;
  logic          game_over_q, game_over_d;

  logic          miss_left;        // ball passed the left pad: right scores
  logic          miss_right;       // ball passed the right pad: left scores
  logic          near_left;
  logic          near_right;

  // One pad step; the low-side test is done before subtracting so it never wraps.
  function automatic logic [8:0] pad_step(input logic [8:0] pad, input logic up, input logic dn);
    logic [8:0] r;
    r = pad;
    if (up && !dn) begin
      r = (pad < PMIN + PSPD) ? PMIN : pad - PSPD;
    end else if (dn && !up) begin
      r = (pad > PMAX - PSPD) ? PMAX : pad + PSPD;
    end
    return r;
  endfunction

  function automatic logic [8:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Pad overlap uses the pad and ball positions held before this tick.
  assign near_left  = (abs_diff(ball_y_q, pad_left_q)  < HIT);
  assign near_right = (abs_diff(ball_y_q, pad_right_q) < HIT);

  // Pads move on every tick regardless of game state.
  always_comb begin
    pad_left_d  = pad_left_q;
    pad_right_d = pad_right_q;
    if (gp.frame_tick) begin
      pad_left_d  = pad_step(pad_left_q,  gp.btn_left_up,  gp.btn_left_down);
      pad_right_d = pad_step(pad_right_q, gp.btn_right_up, gp.btn_right_down);
    end
  end

  // Game state machine: serve countdown, ball flight with bounces, scoring, restart.
  always_comb begin
    state_d       = state_q;
    serve_cnt_d   = serve_cnt_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    point_left_d  = 1'b0;
    point_right_d = 1'b0;
    miss_left     = 1'b0;
    miss_right    = 1'b0;

    if (gp.frame_tick) begin
      unique case (state_q)
        ST_SERVE: begin
          ball_x_d = CX;
          ball_y_d = CY;
          if (serve_cnt_q != '0) begin
            serve_cnt_d = serve_cnt_q - CW'(1);
          end else begin
            state_d = ST_PLAY;
          end
        end

        ST_PLAY: begin
          // Vertical: clamp to the wall and reflect.
          if (dy_q) begin
            if (ball_y_q > BY - BSPD_Y) begin
              ball_y_d = BY;
              dy_d     = 1'b0;
            end else begin
              ball_y_d = ball_y_q + BSPD_Y;
            end
          end else begin
            if (ball_y_q < TY + BSPD_Y) begin
              ball_y_d = TY;
              dy_d     = 1'b1;
            end else begin
              ball_y_d = ball_y_q - BSPD_Y;
            end
          end

          // Horizontal: pad face crossing with overlap reflects, else the edge is a miss.
          if (!dx_q) begin
            if ((ball_x_q >= LX) && (ball_x_q < LX + BSPD_X) && near_left) begin
              ball_x_d = LX;
              dx_d     = 1'b1;
            end else if (ball_x_q < XMIN + BSPD_X) begin
              miss_left = 1'b1;
            end else begin
              ball_x_d = ball_x_q - BSPD_X;
            end
          end else begin
            if ((ball_x_q <= RX) && (ball_x_q > RX - BSPD_X) && near_right) begin
              ball_x_d = RX;
              dx_d     = 1'b0;
            end else if (ball_x_q > XMAX - BSPD_X) begin
              miss_right = 1'b1;
            end else begin
              ball_x_d = ball_x_q + BSPD_X;
            end
          end

          // A point recentres the ball and serves toward the loser; dy is left as it was.
          if (miss_right) begin
            score_left_d = score_left_q + 4'd1;
            point_left_d = 1'b1;
            ball_x_d     = CX;
            ball_y_d     = CY;
            dx_d         = 1'b1;
            dy_d         = dy_q;
            serve_cnt_d  = SERVE_INIT;
            state_d      = (score_left_q + 4'd1 == WIN) ? ST_OVER : ST_SERVE;
          end else if (miss_left) begin
            score_right_d = score_right_q + 4'd1;
            point_right_d = 1'b1;
            ball_x_d      = CX;
            ball_y_d      = CY;
            dx_d          = 1'b0;
            dy_d          = dy_q;
            serve_cnt_d   = SERVE_INIT;
            state_d       = (score_right_q + 4'd1 == WIN) ? ST_OVER : ST_SERVE;
          end
        end

        ST_OVER: begin
          ball_x_d = CX;
          ball_y_d = CY;
          if (gp.btn_start) begin
            score_left_d  = 4'd0;
            score_right_d = 4'd0;
            dx_d          = 1'b1;
            dy_d          = 1'b1;
            serve_cnt_d   = SERVE_INIT;
            state_d       = ST_SERVE;
          end
        end

        default: begin
          state_d = ST_SERVE;
        end
      endcase
    end

    game_over_d = (state_d == ST_OVER);
  end

  // State register; reset asynchronously restores the power-on game.
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_SERVE;
      serve_cnt_q   <= SERVE_INIT;
      pad_left_q    <= CY;
      pad_right_q   <= CY;
      ball_x_q      <= CX;
      ball_y_q      <= CY;
      dx_q          <= 1'b1;
      dy_q          <= 1'b1;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      point_left_q  <= 1'b0;
      point_right_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      serve_cnt_q   <= serve_cnt_d;
      pad_left_q    <= pad_left_d;
      pad_right_q   <= pad_right_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      point_left_q  <= point_left_d;
      point_right_q <= point_right_d;
      game_over_q   <= game_over_d;
    end
  end

  assign gp.pad_left    = pad_left_q;
  assign gp.pad_right   = pad_right_q;
  assign gp.ball_x      = ball_x_q;
  assign gp.ball_y      = ball_y_q;
  assign gp.score_left  = score_left_q;
  assign gp.score_right = score_right_q;
  assign gp.point_left  = point_left_q;
  assign gp.point_right = point_right_q;
  assign gp.game_over   = game_over_q;

endmodule
